// File: rtl/mult_fu_if.sv
// Issue-port and CDB-port bundle of the multiply functional unit.
interface mult_fu_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 6
);
    logic             issue_valid;
    logic             issue_ready;
    logic [1:0]       issue_func;
    logic [XLEN-1:0]  issue_rs1;
    logic [XLEN-1:0]  issue_rs2;
    logic [TAG_W-1:0] issue_tag;
    logic             result_valid;
    logic [XLEN-1:0]  result_value;
    logic [TAG_W-1:0] result_tag;
    logic             cdb_grant;

    modport master (
        output issue_valid, issue_func, issue_rs1, issue_rs2, issue_tag, cdb_grant,
        input  issue_ready, result_valid, result_value, result_tag
    );

    modport slave (
        input  issue_valid, issue_func, issue_rs1, issue_rs2, issue_tag, cdb_grant,
        output issue_ready, result_valid, result_value, result_tag
    );
endinterface

// File: rtl/mult_fu.sv
// RV32M multiply functional unit: pipelined multiplier, tag shadow pipeline, credit-throttled output FIFO.
// Optional MULT_FU_BYPASS_EN forwards the shadow tail straight to the CDB when the FIFO is empty.

// NUM_STAGE-deep multiplier: each stage accumulates one chunk of the sign-extended multiplier.
module mult_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_STAGE = 4
) (
    input  logic              clock,
    input  logic              start,
    input  logic [1:0]        sign,
    input  logic [XLEN-1:0]   mcand,
    input  logic [XLEN-1:0]   mplier,
    output logic [2*XLEN-1:0] product
);
    localparam int unsigned PW = 2 * XLEN;
    localparam int unsigned CW = PW / NUM_STAGE;

    logic [PW-1:0] cand_ext;
    logic [PW-1:0] plier_ext;
    logic [PW-1:0] acc_q   [NUM_STAGE];
    logic [PW-1:0] cand_q  [NUM_STAGE];
    logic [PW-1:0] plier_q [NUM_STAGE];

    // sign is {mplier_signed, mcand_signed}
    assign cand_ext  = sign[0] ? {{XLEN{mcand[XLEN-1]}}, mcand}   : {{XLEN{1'b0}}, mcand};
    assign plier_ext = sign[1] ? {{XLEN{mplier[XLEN-1]}}, mplier} : {{XLEN{1'b0}}, mplier};

    function automatic logic [PW-1:0] partial(input logic [PW-1:0] cand,
                                              input logic [PW-1:0] plier,
                                              input int unsigned   k);
        logic [CW-1:0] chunk;
        chunk = plier[k*CW +: CW];
        return (cand * PW'(chunk)) << (k * CW);
    endfunction

    // Stage 0 only loads on start; stale products drain unqualified and are dropped downstream.
    always_ff @(posedge clock) begin
        if (start) begin
            acc_q[0]   <= partial(cand_ext, plier_ext, 0);
            cand_q[0]  <= cand_ext;
            plier_q[0] <= plier_ext;
        end
        for (int unsigned k = 1; k < NUM_STAGE; k++) begin
            acc_q[k]   <= acc_q[k-1] + partial(cand_q[k-1], plier_q[k-1], k);
            cand_q[k]  <= cand_q[k-1];
            plier_q[k] <= plier_q[k-1];
        end
    end

    assign product = acc_q[NUM_STAGE-1];
endmodule

module mult_fu #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_STAGE = 4,
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     squash,
    mult_fu_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        FUNC_MUL    = 2'b00,
        FUNC_MULH   = 2'b01,
        FUNC_MULHSU = 2'b10,
        FUNC_MULHU  = 2'b11
    } func_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             hi_sel;
    } shadow_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } entry_t;

    func_e             func;
    logic              accept;
    logic [1:0]        sign;
    logic              hi_sel;
    logic [2*XLEN-1:0] product;

    shadow_t           shadow_q [NUM_STAGE];
    shadow_t           tail;
    entry_t            tail_result;
    entry_t            fifo_q [OUT_DEPTH];
    entry_t            head;

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [SUM_W-1:0]  credit_d;
    logic              ready_q;

    logic              fifo_empty;
    logic              bypass;
    logic              out_valid;
    logic              pop;
    logic              tail_write;

    assign func   = func_e'(bus.issue_func);
    assign accept = bus.issue_valid && ready_q && !squash;

    // Operand sign and product-half selection per opcode.
    always_comb begin
        sign   = 2'b00;
        hi_sel = 1'b1;
        case (func)
            FUNC_MUL:    hi_sel = 1'b0;
            FUNC_MULH:   sign   = 2'b11;
            FUNC_MULHSU: sign   = 2'b01;
            FUNC_MULHU:  sign   = 2'b00;
            default:     sign   = 2'b00;
        endcase
    end

    mult_pipe #(
        .XLEN      (XLEN),
        .NUM_STAGE (NUM_STAGE)
    ) u_mult (
        .clock   (clock),
        .start   (accept),
        .sign    (sign),
        .mcand   (bus.issue_rs1),
        .mplier  (bus.issue_rs2),
        .product (product)
    );

    assign tail              = shadow_q[NUM_STAGE-1];
    assign tail_result.tag   = tail.tag;
    assign tail_result.value = tail.hi_sel ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];

    assign fifo_empty = (count_q == '0);

`ifdef MULT_FU_BYPASS_EN
    assign bypass = fifo_empty && tail.valid;
`else
    assign bypass = 1'b0;
`endif

    // Head mux reads registered FIFO state; zero when nothing is presented.
    always_comb begin
        head = '0;
        if (!fifo_empty) begin
            head = fifo_q[rd_ptr_q];
        end else if (bypass) begin
            head = tail_result;
        end
    end

    assign out_valid  = !fifo_empty || bypass;
    assign pop        = out_valid && bus.cdb_grant && !fifo_empty;
    assign tail_write = tail.valid && !(bypass && bus.cdb_grant);

    assign inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(tail.valid);
    assign count_d    = count_q + CNT_W'(tail_write) - CNT_W'(pop);
    assign credit_d   = SUM_W'(inflight_d) + SUM_W'(count_d);

    // Control state: shadow valids, credits and pointers; squash behaves like reset.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            for (int unsigned i = 0; i < NUM_STAGE; i++) begin
                shadow_q[i] <= '0;
            end
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ready_q    <= 1'b1;
        end else begin
            shadow_q[0] <= '{valid: accept, tag: bus.issue_tag, hi_sel: hi_sel};
            for (int unsigned i = 1; i < NUM_STAGE; i++) begin
                shadow_q[i] <= shadow_q[i-1];
            end
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (tail_write) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            ready_q <= (credit_d < SUM_W'(OUT_DEPTH));
        end
    end

    // FIFO storage needs no reset; occupancy gates visibility.
    always_ff @(posedge clock) begin
        if (tail_write && !reset && !squash) begin
            fifo_q[wr_ptr_q] <= tail_result;
        end
    end

    assign bus.issue_ready  = ready_q;
    assign bus.result_valid = out_valid;
    assign bus.result_value = head.value;
    assign bus.result_tag   = head.tag;

    a_no_overflow: assert property (@(posedge clock) disable iff (reset || squash)
        !(tail_write && !pop && count_q == CNT_W'(OUT_DEPTH)));

    a_credit_bound: assert property (@(posedge clock) disable iff (reset || squash)
        (SUM_W'(inflight_q) + SUM_W'(count_q)) <= SUM_W'(OUT_DEPTH));
endmodule

// File: doc/mult_fu.md
# mult_fu

Multiply functional unit wrapping the `NUM_STAGE`-deep pipelined multiplier between the reservation-station issue port and the CDB. Decodes the four RV32M multiply ops, drives multiplier operand signs, and carries tags through a shadow pipeline alongside the datapath. Selects the low or high product half and buffers results in a small output FIFO until CDB grant. The multiplier cannot stall, so issue is throttled by credits.

## Interface
- `XLEN`, 32, operand/result width
- `NUM_STAGE`, 4, multiplier pipeline depth; must match the instantiated multiplier
- `TAG_W`, 6, ROB tag width
- `OUT_DEPTH`, 4, output FIFO entries; power of two, ≥2
- `clock` in 1 — clock
- `reset` in 1 — synchronous, active-high
- `squash` in 1 — mispredict flush, synchronous
- `issue_valid` in 1 — RS presents an op
- `issue_ready` out 1 — unit can accept an op
- `issue_func` in 2 — 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- `issue_rs1` in XLEN — multiplicand
- `issue_rs2` in XLEN — multiplier
- `issue_tag` in TAG_W — destination tag
- `result_valid` out 1 — FIFO head (or bypass) valid
- `result_value` out XLEN — selected product half
- `result_tag` out TAG_W — tag of the result
- `cdb_grant` in 1 — CDB accepts the result this cycle

## Operation
- Accept when `issue_valid && issue_ready && !squash`.
- Multiplier drive: `mcand=rs1`, `mplier=rs2`, `start`=accept. Sign vector `{mplier_signed, mcand_signed}`: MUL 2'b00, MULH 2'b11, MULHSU 2'b01, MULHU 2'b00.
- Shadow pipeline: NUM_STAGE registers of `{valid, tag, hi_sel}`. `hi_sel=1` for MULH/MULHSU/MULHU. Entry 0 is written on accept; shifts every cycle.
- At the shadow pipeline tail, when valid: write `{tag, hi_sel ? product[2*XLEN-1:XLEN] : product[XLEN-1:0]}` into the FIFO. Multiplier `done` is ignored for qualification; shadow valid is authoritative.
- `inflight` counter (0..OUT_DEPTH): +1 on accept, −1 on tail write.
- `count` (FIFO occupancy): +1 on write, −1 on pop (`result_valid && cdb_grant`). Simultaneous write and pop leaves count unchanged.
- `issue_ready = (inflight + count) < OUT_DEPTH`, computed from registered state only. There is no combinational path from `cdb_grant` or `issue_valid`. This guarantees a FIFO slot for every in-flight op; FIFO overflow is impossible.
- FIFO pointers wrap modulo OUT_DEPTH.
- `squash`: clears all shadow valids, `inflight`, `count`, and pointers at the clock edge. An accept attempted in the squash cycle is dropped. Products still in the multiplier drain out unqualified and are discarded.
- `reset`: same effect as `squash`. Reset values: `issue_ready=1` (after the edge), `result_valid=0`, `result_value=0`, `result_tag=0`.

## Timing
- Op accepted in cycle N; tail write at the end of cycle N+NUM_STAGE; `result_valid` in cycle N+NUM_STAGE+1 (default 5 cycles).
- Back-to-back issue supported: one op per cycle while credits remain.
- With no grants, at most OUT_DEPTH ops are accepted. `issue_ready` rises the cycle after the first pop.
- The pop advances the head at the edge. The next entry is visible the following cycle, so draining a full FIFO takes one result per cycle.
- `result_value`/`result_tag` are stable while `result_valid && !cdb_grant`.

## Configuration
- `MULT_FU_BYPASS_EN` defined: when the FIFO is empty and the shadow tail is valid, the tail result drives `result_*` combinationally in cycle N+NUM_STAGE.
  - If granted that cycle, it is not written to the FIFO.
  - If not granted, it is written and appears again next cycle.
  - Latency becomes NUM_STAGE.
- Not defined: all results pass through the FIFO; latency NUM_STAGE+1.

## Test plan
- MUL 7×6, tag 3, grant held high → `result_valid` in cycle N+5, value 42, tag 3. With bypass: cycle N+4.
- MULH rs1=0xFFFFFFFE (−2), rs2=3 → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF.
- Grant held low, issue_valid held high, tags 1..6 → exactly tags 1–4 accepted and `issue_ready` low. Then grant for 4 cycles → results 1,2,3,4 in order; `issue_ready` high the cycle after the first pop.
- Issue tags 1,2,3 back-to-back; assert `squash` in cycle N+2 → no result ever appears for tags 1–3. Tag 9 issued in cycle N+3 → returns in cycle N+8 with the correct value.
- Issue 2 ops, no grant; assert `reset` mid-flight → `result_valid=0` and `issue_ready=1` the cycle after reset; no stale results afterwards.
- Simultaneous tail write and pop with count=2 → count stays 2; result order is preserved across pointer wrap (issue 10 ops with grant toggling every cycle).
